floor_request_scheduler: RTL and testbench
==========================================

// Module: floor_request_scheduler
// PURPOSE
//  Upstream stage of the elevator FSM controller. Latches floor-call buttons into a pending set.
//  Picks the next target floor with SCAN ordering (keep direction while calls remain ahead).
//  Drives up_request/down_request/target_floor into the controller and monitors its
//  move_up/move_down/door_open outputs to retire serviced calls.
// PARAMETERS
//  NUM_FLOORS  4  number of floors served; floor_call/pending width
//  FLOOR_W     2  floor index width; NUM_FLOORS <= 2**FLOOR_W
// PORTS
//  clk             in   1           single clock, all logic on posedge
//  reset_n         in   1           synchronous, active-low reset
//  floor_call      in   NUM_FLOORS  call buttons, bit i = floor i; level or pulse, sampled every cycle
//  current_floor   in   FLOOR_W     floor sensor, same value the controller sees
//  move_up         in   1           from controller: car moving up
//  move_down       in   1           from controller: car moving down
//  door_open       in   1           from controller: door open
//  emergency_stop  in   1           same emergency line the controller receives
//  up_request      out  1           to controller: request upward trip
//  down_request    out  1           to controller: request downward trip
//  target_floor    out  FLOOR_W     to controller: destination floor
//  pending         out  NUM_FLOORS  outstanding calls, bit i = floor i
//  dir_up          out  1           SCAN direction: 1 = up, 0 = down
//  state           out  3           debug copy of FSM state
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): state=IDLE, pending=0, target_floor=0, up_request=0,
//   down_request=0, dir_up=1, door_open_d=0. All outputs are registered.
//  pending update, each cycle: pending <= (pending | floor_call) & ~clr.
//   - clr is one-hot at target_floor for one cycle when door_open rises (door_open & ~door_open_d)
//     in TRAVEL with current_floor==target_floor.
//   - In IDLE, a call for current_floor is dropped (never latched); the car is already there.
//   - floor_call bit for target_floor on the same cycle as clr: clear wins (call is being served).
//  SCAN select (combinational on pending, current_floor, dir_up):
//   - above = nearest pending floor > current_floor; below = nearest pending floor < current_floor.
//   - If dir_up and above exists -> pick above. Else if below exists -> pick below.
//   - Else if above exists -> pick above. Direction flips only when nothing is ahead.
//  FSM states (encoding in parentheses):
//   IDLE(0): on emergency_stop -> HOLD. Else if a candidate exists: latch target_floor and dir_up.
//     Then go to REQ_UP(1) if target > current_floor, or REQ_DOWN(2) otherwise. No candidate -> stay.
//   REQ_UP/REQ_DOWN: hold up_request (resp. down_request)=1 and target_floor stable.
//     When move_up (resp. move_down) is seen -> drop request, go to TRAVEL(3). emergency_stop -> HOLD.
//   TRAVEL(3): request lines 0.
//     Re-target: a pending floor strictly between current_floor and target_floor in the travel
//      direction replaces target_floor next cycle. Nearest one wins.
//     door_open rise at target -> clr, go to DOOR(4). emergency_stop -> HOLD.
//   DOOR(4): wait for door_open==0 -> IDLE. emergency_stop -> HOLD.
//   HOLD(5): request lines 0; pending, target_floor and dir_up are retained; new calls still latch.
//     emergency_stop==0 -> IDLE, where a fresh SCAN select is made.
//   Codes 6-7: -> IDLE next cycle, request lines 0.
//  Latency:
//   - Call to request: call at cycle N -> pending at N+1 -> up/down_request at N+2 (IDLE case).
//   - up_request and down_request are never both 1.
//   - target_floor changes only in IDLE and on a TRAVEL re-target.
//  Reset mid-operation returns every register to its reset value and discards all pending calls.
// TESTING
//  1. Reset, current=0, pulse floor_call=4'b1000 -> pending=1000 next cycle; up_request=1 and
//     target=3 at cycle+2. Model moves car, door opens at 3 -> pending=0000, DOOR, then IDLE on door close.
//  2. current=0 travelling to 3, floor_call[2] pulsed while current=1 -> target_floor becomes 2.
//     Door at 2 clears bit 2 only; next IDLE issues up_request with target=3.
//  3. current=2, dir_up=1, pending=1001 -> target=3 first. After servicing 3, down_request
//     with target=0 and dir_up=0.
//  4. In REQ_UP, assert emergency_stop -> HOLD next cycle, up_request=0, pending kept.
//     Release -> IDLE, then request re-issued one cycle later.
//  5. IDLE at current=1, floor_call=0010 -> pending stays 0000, no request. Call to floor 1
//     coinciding with its door-open clear -> bit stays 0.
//  6. Assert reset_n=0 in TRAVEL with pending=0110 -> next cycle state=IDLE, pending=0,
//     target=0, dir_up=1, requests 0.

Source files
------------

// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
//
// Upstream stage of the elevator controller. Floor-call buttons are latched
// into a pending set; the next target floor is chosen with SCAN ordering (the
// car keeps its direction while calls remain ahead of it). The block raises
// up/down requests toward the controller and watches the controller's
// move/door outputs to retire calls once they have been served.
//
// Ports
//   i_clk             single clock, all logic on posedge
//   i_reset_n         synchronous, active-low reset
//   i_floor_call      call buttons, bit i = floor i (level or pulse)
//   i_current_floor   floor sensor, same value the controller sees
//   i_move_up         controller: car moving up
//   i_move_down       controller: car moving down
//   i_door_open       controller: door open
//   i_emergency_stop  emergency line shared with the controller
//   o_up_request      request an upward trip
//   o_down_request    request a downward trip
//   o_target_floor    destination floor handed to the controller
//   o_pending         outstanding calls, bit i = floor i
//   o_dir_up          SCAN direction, 1 = up, 0 = down
//   o_state           debug copy of the FSM state
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_FLOORS-1:0] i_floor_call,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  input  logic                  i_move_up,
  input  logic                  i_move_down,
  input  logic                  i_door_open,
  input  logic                  i_emergency_stop,
  output logic                  o_up_request,
  output logic                  o_down_request,
  output logic [FLOOR_W-1:0]    o_target_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_up,
  output logic [2:0]            o_state
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ_UP   = 3'd1;
  localparam logic [2:0] ST_REQ_DOWN = 3'd2;
  localparam logic [2:0] ST_TRAVEL   = 3'd3;
  localparam logic [2:0] ST_DOOR     = 3'd4;
  localparam logic [2:0] ST_HOLD     = 3'd5;

  logic [2:0]            r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_target;
  logic                  r_up_req;
  logic                  r_down_req;
  logic                  r_dir_up;
  logic                  r_door_open_d;

  // Per-floor decode of the sensor and of the latched target.
  logic [NUM_FLOORS-1:0] w_cur_bit;
  logic [NUM_FLOORS-1:0] w_tgt_bit;

  // SCAN candidates relative to the current floor.
  logic                  w_above_vld;
  logic [FLOOR_W-1:0]    w_above;
  logic                  w_below_vld;
  logic [FLOOR_W-1:0]    w_below;
  logic                  w_cand_vld;
  logic [FLOOR_W-1:0]    w_cand;
  logic                  w_cand_up;

  // Nearest pending floor strictly between the car and its target.
  logic                  w_retgt_vld;
  logic [FLOOR_W-1:0]    w_retgt;

  logic                  w_door_rise;
  logic                  w_at_target;
  logic                  w_serve;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_call_mask;

  always_comb begin
    w_cur_bit   = '0;
    w_tgt_bit   = '0;
    w_above_vld = 1'b0;
    w_above     = '0;
    w_below_vld = 1'b0;
    w_below     = '0;
    w_retgt_vld = 1'b0;
    w_retgt     = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      w_cur_bit[i] = (FLOOR_W'(i) == i_current_floor);
      w_tgt_bit[i] = (FLOOR_W'(i) == r_target);
      // Ascending scan: first hit above is the nearest above; last hit
      // below is the nearest below.
      if (r_pending[i] && (FLOOR_W'(i) > i_current_floor) && !w_above_vld) begin
        w_above_vld = 1'b1;
        w_above     = FLOOR_W'(i);
      end
      if (r_pending[i] && (FLOOR_W'(i) < i_current_floor)) begin
        w_below_vld = 1'b1;
        w_below     = FLOOR_W'(i);
      end
      // Re-target: going up, the lowest intermediate floor is nearest;
      // going down, the highest one is.
      if (r_pending[i]) begin
        if (r_dir_up) begin
          if ((FLOOR_W'(i) > i_current_floor) && (FLOOR_W'(i) < r_target) && !w_retgt_vld) begin
            w_retgt_vld = 1'b1;
            w_retgt     = FLOOR_W'(i);
          end
        end else begin
          if ((FLOOR_W'(i) < i_current_floor) && (FLOOR_W'(i) > r_target)) begin
            w_retgt_vld = 1'b1;
            w_retgt     = FLOOR_W'(i);
          end
        end
      end
    end
  end

  // Keep direction while something lies ahead; flip only when nothing does.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = '0;
    if (r_dir_up && w_above_vld) begin
      w_cand_vld = 1'b1;
      w_cand     = w_above;
    end else if (w_below_vld) begin
      w_cand_vld = 1'b1;
      w_cand     = w_below;
    end else if (w_above_vld) begin
      w_cand_vld = 1'b1;
      w_cand     = w_above;
    end
    w_cand_up = (w_cand > i_current_floor);
  end

  always_comb begin
    w_door_rise = i_door_open & ~r_door_open_d;
    w_at_target = (i_current_floor == r_target);
    w_serve     = (r_state == ST_TRAVEL) && w_door_rise && w_at_target;
    w_clr       = w_serve ? w_tgt_bit : '0;
    // A call for the floor the idle car already sits at is never latched.
    w_call_mask = (r_state == ST_IDLE) ? ~w_cur_bit : '1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_target      <= '0;
      r_up_req      <= 1'b0;
      r_down_req    <= 1'b0;
      r_dir_up      <= 1'b1;
      r_door_open_d <= 1'b0;
    end else begin
      r_door_open_d <= i_door_open;
      // Clear is applied last so a call arriving on its serve cycle is dropped.
      r_pending     <= (r_pending | (i_floor_call & w_call_mask)) & ~w_clr;

      case (r_state)
        ST_IDLE: begin
          r_up_req   <= 1'b0;
          r_down_req <= 1'b0;
          if (i_emergency_stop) begin
            r_state <= ST_HOLD;
          end else if (w_cand_vld) begin
            r_target <= w_cand;
            r_dir_up <= w_cand_up;
            if (w_cand_up) begin
              r_up_req <= 1'b1;
              r_state  <= ST_REQ_UP;
            end else begin
              r_down_req <= 1'b1;
              r_state    <= ST_REQ_DOWN;
            end
          end
        end

        ST_REQ_UP: begin
          r_down_req <= 1'b0;
          if (i_emergency_stop) begin
            r_up_req <= 1'b0;
            r_state  <= ST_HOLD;
          end else if (i_move_up) begin
            r_up_req <= 1'b0;
            r_state  <= ST_TRAVEL;
          end else begin
            r_up_req <= 1'b1;
          end
        end

        ST_REQ_DOWN: begin
          r_up_req <= 1'b0;
          if (i_emergency_stop) begin
            r_down_req <= 1'b0;
            r_state    <= ST_HOLD;
          end else if (i_move_down) begin
            r_down_req <= 1'b0;
            r_state    <= ST_TRAVEL;
          end else begin
            r_down_req <= 1'b1;
          end
        end

        ST_TRAVEL: begin
          r_up_req   <= 1'b0;
          r_down_req <= 1'b0;
          if (i_emergency_stop) begin
            r_state <= ST_HOLD;
          end else if (w_serve) begin
            r_state <= ST_DOOR;
          end else if (w_retgt_vld) begin
            r_target <= w_retgt;
          end
        end

        ST_DOOR: begin
          r_up_req   <= 1'b0;
          r_down_req <= 1'b0;
          if (i_emergency_stop) begin
            r_state <= ST_HOLD;
          end else if (!i_door_open) begin
            r_state <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          r_up_req   <= 1'b0;
          r_down_req <= 1'b0;
          if (!i_emergency_stop) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_up_req   <= 1'b0;
          r_down_req <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_up_request   = r_up_req;
  assign o_down_request = r_down_req;
  assign o_target_floor = r_target;
  assign o_pending      = r_pending;
  assign o_dir_up       = r_dir_up;
  assign o_state        = r_state;

endmodule

// File: tb/tb_floor_request_scheduler.sv
module tb_floor_request_scheduler;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [3:0] i_floor_call;
  logic [1:0] i_current_floor;
  logic       i_move_up;
  logic       i_move_down;
  logic       i_door_open;
  logic       i_emergency_stop;
  logic       o_up_request;
  logic       o_down_request;
  logic [1:0] o_target_floor;
  logic [3:0] o_pending;
  logic       o_dir_up;
  logic [2:0] o_state;

  int n_vec = 0;
  int n_err = 0;

  floor_request_scheduler #(
    .NUM_FLOORS(4),
    .FLOOR_W   (2)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_floor_call    (i_floor_call),
    .i_current_floor (i_current_floor),
    .i_move_up       (i_move_up),
    .i_move_down     (i_move_down),
    .i_door_open     (i_door_open),
    .i_emergency_stop(i_emergency_stop),
    .o_up_request    (o_up_request),
    .o_down_request  (o_down_request),
    .o_target_floor  (o_target_floor),
    .o_pending       (o_pending),
    .o_dir_up        (o_dir_up),
    .o_state         (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] cur);
    i_reset_n        = 1'b0;
    i_floor_call     = 4'b0000;
    i_current_floor  = cur;
    i_move_up        = 1'b0;
    i_move_down      = 1'b0;
    i_door_open      = 1'b0;
    i_emergency_stop = 1'b0;
    tick();
    i_reset_n = 1'b1;
  endtask

  // Never both requests at once; sampled on the inactive edge.
  always @(negedge i_clk) begin
    if (i_reset_n === 1'b1) begin
      chk("req_exclusive", {31'd0, o_up_request & o_down_request}, 32'd0);
    end
  end

  initial begin
    // ---- 1: basic call to floor 3 ----
    do_reset(2'd0);
    chk("t1_rst_state",  o_state,        3'd0);
    chk("t1_rst_pend",   o_pending,      4'b0000);
    chk("t1_rst_tgt",    o_target_floor, 2'd0);
    chk("t1_rst_up",     o_up_request,   1'b0);
    chk("t1_rst_down",   o_down_request, 1'b0);
    chk("t1_rst_dir",    o_dir_up,       1'b1);
    i_floor_call = 4'b1000;
    tick();
    chk("t1_pend_n1",    o_pending,      4'b1000);
    chk("t1_noreq_n1",   o_up_request,   1'b0);
    i_floor_call = 4'b0000;
    tick();
    chk("t1_up_n2",      o_up_request,   1'b1);
    chk("t1_tgt_n2",     o_target_floor, 2'd3);
    chk("t1_state_req",  o_state,        3'd1);
    i_move_up = 1'b1;
    tick();
    chk("t1_travel",     o_state,        3'd3);
    chk("t1_up_drop",    o_up_request,   1'b0);
    i_current_floor = 2'd1; tick();
    i_current_floor = 2'd2; tick();
    i_current_floor = 2'd3; i_move_up = 1'b0; tick();
    chk("t1_pend_kept",  o_pending,      4'b1000);
    i_door_open = 1'b1;
    tick();
    chk("t1_pend_clr",   o_pending,      4'b0000);
    chk("t1_door",       o_state,        3'd4);
    tick();
    chk("t1_door_hold",  o_state,        3'd4);
    i_door_open = 1'b0;
    tick();
    chk("t1_idle",       o_state,        3'd0);
    chk("t1_idle_noreq", o_up_request,   1'b0);

    // ---- 2: re-target to an intermediate floor ----
    do_reset(2'd0);
    i_floor_call = 4'b1000; tick();
    i_floor_call = 4'b0000; tick();
    chk("t2_tgt3",       o_target_floor, 2'd3);
    i_move_up = 1'b1; tick();
    i_current_floor = 2'd1;
    i_floor_call = 4'b0100; tick();
    chk("t2_tgt_hold",   o_target_floor, 2'd3);
    i_floor_call = 4'b0000; tick();
    chk("t2_retgt",      o_target_floor, 2'd2);
    chk("t2_travel",     o_state,        3'd3);
    chk("t2_pend",       o_pending,      4'b1100);
    i_current_floor = 2'd2; i_move_up = 1'b0; i_door_open = 1'b1; tick();
    chk("t2_clr2",       o_pending,      4'b1000);
    chk("t2_door",       o_state,        3'd4);
    i_door_open = 1'b0; tick();
    chk("t2_idle",       o_state,        3'd0);
    tick();
    chk("t2_up_again",   o_up_request,   1'b1);
    chk("t2_tgt_again",  o_target_floor, 2'd3);

    // ---- 3: SCAN direction reversal ----
    do_reset(2'd2);
    i_floor_call = 4'b1001; tick();
    chk("t3_pend",       o_pending,      4'b1001);
    i_floor_call = 4'b0000; tick();
    chk("t3_tgt3",       o_target_floor, 2'd3);
    chk("t3_up",         o_up_request,   1'b1);
    i_move_up = 1'b1; tick();
    i_current_floor = 2'd3; i_move_up = 1'b0; i_door_open = 1'b1; tick();
    chk("t3_pend_left",  o_pending,      4'b0001);
    i_door_open = 1'b0; tick();
    tick();
    chk("t3_down",       o_down_request, 1'b1);
    chk("t3_noup",       o_up_request,   1'b0);
    chk("t3_tgt0",       o_target_floor, 2'd0);
    chk("t3_dir",        o_dir_up,       1'b0);
    chk("t3_state",      o_state,        3'd2);

    // ---- 4: emergency stop during REQ_UP ----
    do_reset(2'd0);
    i_floor_call = 4'b0100; tick();
    i_floor_call = 4'b0000; tick();
    chk("t4_req",        o_state,        3'd1);
    i_emergency_stop = 1'b1; tick();
    chk("t4_hold",       o_state,        3'd5);
    chk("t4_up0",        o_up_request,   1'b0);
    chk("t4_pend",       o_pending,      4'b0100);
    chk("t4_tgt",        o_target_floor, 2'd2);
    i_floor_call = 4'b1000; tick();
    i_floor_call = 4'b0000;
    chk("t4_hold_latch", o_pending,      4'b1100);
    chk("t4_hold2",      o_state,        3'd5);
    i_emergency_stop = 1'b0; tick();
    chk("t4_idle",       o_state,        3'd0);
    chk("t4_idle_up0",   o_up_request,   1'b0);
    tick();
    chk("t4_reissue",    o_up_request,   1'b1);
    chk("t4_tgt2",       o_target_floor, 2'd2);

    // ---- 5: call at current floor, and call vs clear ----
    do_reset(2'd1);
    i_floor_call = 4'b0010; tick();
    chk("t5_drop",       o_pending,      4'b0000);
    i_floor_call = 4'b0000; tick();
    chk("t5_noreq",      o_up_request | o_down_request, 1'b0);
    chk("t5_idle",       o_state,        3'd0);
    i_current_floor = 2'd0;
    i_floor_call = 4'b0010; tick();
    chk("t5_latch",      o_pending,      4'b0010);
    i_floor_call = 4'b0000; tick();
    chk("t5_tgt1",       o_target_floor, 2'd1);
    i_move_up = 1'b1; tick();
    i_current_floor = 2'd1; i_move_up = 1'b0; i_door_open = 1'b1;
    i_floor_call = 4'b0010; tick();
    i_floor_call = 4'b0000;
    chk("t5_clr_wins",   o_pending,      4'b0000);
    chk("t5_door",       o_state,        3'd4);
    i_door_open = 1'b0; tick();

    // ---- 6: reset in TRAVEL ----
    do_reset(2'd0);
    i_floor_call = 4'b0110; tick();
    i_floor_call = 4'b0000; tick();
    chk("t6_tgt1",       o_target_floor, 2'd1);
    i_move_up = 1'b1; tick();
    chk("t6_travel",     o_state,        3'd3);
    chk("t6_pend",       o_pending,      4'b0110);
    i_reset_n = 1'b0; tick();
    chk("t6_state",      o_state,        3'd0);
    chk("t6_pend0",      o_pending,      4'b0000);
    chk("t6_tgt0",       o_target_floor, 2'd0);
    chk("t6_dir",        o_dir_up,       1'b1);
    chk("t6_up",         o_up_request,   1'b0);
    chk("t6_down",       o_down_request, 1'b0);
    i_reset_n = 1'b1;
    i_move_up = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
